// File: rtl/voice_slot_scheduler.sv
// voice_slot_scheduler
//   Derives the synth sample-rate strobe from the 50 MHz system clock with a
//   programmable divider. On every accepted strobe it walks the shared voice
//   datapath through NUM_VOICES slots using a valid/ready handshake. A strobe
//   that arrives before the previous frame has finished is dropped and flagged
//   with a sticky overrun.
//
// Ports
//   i_clk50mhz    system clock, all logic on rising edge
//   i_rst_n       asynchronous active-low reset
//   i_enable      1 = divider runs, 0 = divider held at zero
//   i_div         new divisor value (period = divisor + 1 clocks)
//   i_div_load    strobe: capture i_div into the shadow register
//   i_ovr_clr     strobe: clear o_overrun
//   i_slot_ready  datapath accepts the current slot
//   o_sample_tick 1-cycle pulse per sample period
//   o_slot_valid  slot request to the datapath
//   o_slot_idx    voice index of the current request
//   o_frame_done  1-cycle pulse after the last slot is accepted
//   o_busy        frame in progress
//   o_overrun     sticky: strobe arrived while a frame was in progress
module voice_slot_scheduler #(
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 1133,
    parameter int NUM_VOICES  = 8,
    parameter int VOICE_W     = 3
) (
    input  logic               i_clk50mhz,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic [DIV_W-1:0]   i_div,
    input  logic               i_div_load,
    input  logic               i_ovr_clr,
    input  logic               i_slot_ready,
    output logic               o_sample_tick,
    output logic               o_slot_valid,
    output logic [VOICE_W-1:0] o_slot_idx,
    output logic               o_frame_done,
    output logic               o_busy,
    output logic               o_overrun
);

    localparam logic [DIV_W-1:0]   DIV_RST  = DIV_W'(DIV_DEFAULT);
    localparam logic [VOICE_W-1:0] LAST_IDX = VOICE_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [VOICE_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0]   cnt_q;
    logic [DIV_W-1:0]   div_act_q;
    logic [DIV_W-1:0]   div_shadow_q;
    logic               overrun_q;
    logic               wrap;

    // Gated by reset so the strobe stays low while held in reset even for a
    // zero default divisor.
    assign wrap = i_rst_n && i_enable && (cnt_q == div_act_q);

    // Divider. The shadow only reaches the active divisor on a wrap, so a
    // reload never shortens the period in progress. A load coinciding with a
    // wrap lands in the shadow after the wrap has already copied the old one.
    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q        <= '0;
            div_act_q    <= DIV_RST;
            div_shadow_q <= DIV_RST;
        end else begin
            if (i_div_load) begin
                div_shadow_q <= i_div;
            end
            if (!i_enable) begin
                cnt_q <= '0;
            end else if (wrap) begin
                cnt_q     <= '0;
                div_act_q <= div_shadow_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (wrap) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                // Without ready, valid and idx simply hold.
                if (i_slot_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // A strobe outside IDLE is dropped by the FSM; record it here. Set has
    // priority over a simultaneous clear.
    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overrun_q <= 1'b0;
        end else if (wrap && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
        end else if (i_ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign o_sample_tick = wrap;
    assign o_slot_valid  = (state_q == ISSUE);
    assign o_slot_idx    = idx_q;
    assign o_frame_done  = (state_q == DONE);
    assign o_busy        = (state_q != IDLE);
    assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_voice_slot_scheduler.sv
// Directed bench for voice_slot_scheduler with default parameters
// (divisor 1133, 8 voices). Outputs are sampled 1 ns after each rising edge;
// inputs are changed at the same point, after sampling. A tick becomes
// visible in the cycle where the counter equals the divisor, i.e. div edges
// after the counter starts from zero (the div+1-th clock of the period).
module tb_voice_slot_scheduler;

    logic        i_clk50mhz = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic [15:0] i_div;
    logic        i_div_load;
    logic        i_ovr_clr;
    logic        i_slot_ready;
    logic        o_sample_tick;
    logic        o_slot_valid;
    logic [2:0]  o_slot_idx;
    logic        o_frame_done;
    logic        o_busy;
    logic        o_overrun;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int prev_tick  = 0;
    int delta;
    int exp_idx;
    bit saw_done;

    always #10 i_clk50mhz = ~i_clk50mhz;

    voice_slot_scheduler #(
        .DIV_W      (16),
        .DIV_DEFAULT(1133),
        .NUM_VOICES (8),
        .VOICE_W    (3)
    ) dut (
        .i_clk50mhz   (i_clk50mhz),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .i_div        (i_div),
        .i_div_load   (i_div_load),
        .i_ovr_clr    (i_ovr_clr),
        .i_slot_ready (i_slot_ready),
        .o_sample_tick(o_sample_tick),
        .o_slot_valid (o_slot_valid),
        .o_slot_idx   (o_slot_idx),
        .o_frame_done (o_frame_done),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk50mhz);
        #1;
        cyc++;
    endtask

    // Advance until a tick is visible; d = clocks since the previous tick.
    task automatic wait_tick(input int limit, output int d);
        bit seen;
        seen = 1'b0;
        d = -1;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (o_sample_tick === 1'b1) seen = 1'b1;
        end
        chk("tick_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            d = cyc - prev_tick;
            prev_tick = cyc;
        end
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_enable     = 1'b1;
        i_div        = '0;
        i_div_load   = 1'b0;
        i_ovr_clr    = 1'b0;
        i_slot_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge i_clk50mhz);
        #1;
        chk("rst_tick",    o_sample_tick, 0);
        chk("rst_valid",   o_slot_valid,  0);
        chk("rst_idx",     o_slot_idx,    0);
        chk("rst_done",    o_frame_done,  0);
        chk("rst_busy",    o_busy,        0);
        chk("rst_overrun", o_overrun,     0);
        i_rst_n   = 1'b1;
        cyc       = 0;
        prev_tick = 0;

        // 1: default period and a full frame with ready held high
        wait_tick(2000, delta);
        chk("t1_first_tick", delta, 1133);
        chk("t1_tick_idle_valid", o_slot_valid, 0);
        for (int s = 1; s <= 8; s++) begin
            step();
            chk("t1_valid", o_slot_valid, 1);
            chk("t1_idx",   o_slot_idx,   s - 1);
            chk("t1_busy",  o_busy,       1);
        end
        step();
        chk("t1_frame_done", o_frame_done, 1);
        chk("t1_valid_off",  o_slot_valid, 0);
        step();
        chk("t1_done_pulse", o_frame_done, 0);
        chk("t1_idle",       o_busy,       0);

        // 2: reload mid-period, then reload on the wrap cycle
        i_div = 16'd9; i_div_load = 1'b1;
        step();
        i_div_load = 1'b0;
        wait_tick(2000, delta);
        chk("t2_period_kept", delta, 1134);
        wait_tick(2000, delta);
        chk("t2_period_10", delta, 10);
        chk("t2_idle_at_tick", o_busy, 0);
        i_div = 16'd19; i_div_load = 1'b1;   // on the wrap cycle
        step();
        i_div_load = 1'b0;
        wait_tick(2000, delta);
        chk("t2_wrap_load_deferred", delta, 10);
        repeat (3) step();
        i_div = 16'd99; i_div_load = 1'b1;
        step();
        i_div_load = 1'b0;
        wait_tick(2000, delta);
        chk("t2_period_20", delta, 20);
        chk("t2_no_overrun", o_overrun, 0);

        // 3: ready pattern 1,0,0 repeating; each index issued once, in order
        step();
        exp_idx = 0;
        for (int k = 0; k < 22; k++) begin
            chk("t3_valid", o_slot_valid, 1);
            chk("t3_idx",   o_slot_idx,   exp_idx);
            i_slot_ready = (k % 3 == 0);
            step();
            if (i_slot_ready) exp_idx++;
        end
        chk("t3_all_issued", exp_idx, 8);
        chk("t3_frame_done", o_frame_done, 1);
        i_slot_ready = 1'b1;

        // 4: divisor 5 overruns an 8-voice frame
        i_div = 16'd5; i_div_load = 1'b1;
        step();
        i_div_load = 1'b0;
        wait_tick(2000, delta);
        chk("t4_period_100", delta, 100);
        repeat (5) step();
        step();                                   // s=6
        chk("t4_tick_busy", o_sample_tick, 1);
        chk("t4_idx_s6",    o_slot_idx,    5);
        chk("t4_ovr_before", o_overrun,    0);
        step();                                   // s=7
        chk("t4_ovr_set",     o_overrun,  1);
        chk("t4_no_restart",  o_slot_idx, 6);
        step(); step();                           // s=9
        chk("t4_frame_done", o_frame_done, 1);
        step();                                   // s=10
        chk("t4_idle", o_busy, 0);
        i_ovr_clr = 1'b1;
        step();                                   // s=11
        i_ovr_clr = 1'b0;
        chk("t4_ovr_cleared", o_overrun, 0);
        step();                                   // s=12
        chk("t4_tick_idle", o_sample_tick, 1);
        chk("t4_tick_idle_busy", o_busy,  0);
        step();                                   // s=13
        chk("t4_new_frame_valid", o_slot_valid, 1);
        chk("t4_new_frame_idx",   o_slot_idx,   0);
        chk("t4_ovr_still_clear", o_overrun,    0);
        repeat (5) step();                        // s=18
        chk("t4_tick2_busy", o_sample_tick, 1);
        chk("t4_tick2_busy_b", o_busy, 1);
        i_ovr_clr = 1'b1;
        step();                                   // s=19
        i_ovr_clr = 1'b0;
        chk("t4_set_wins",   o_overrun,  1);
        chk("t4_idx_s19",    o_slot_idx, 6);
        prev_tick = cyc - 1;

        // 5: enable low mid-frame
        i_div = 16'd29; i_div_load = 1'b1;
        step();
        i_div_load = 1'b0;
        wait_tick(2000, delta);
        chk("t5_period_6", delta, 6);
        i_ovr_clr = 1'b1;
        step();
        i_ovr_clr = 1'b0;
        chk("t5_ovr_cleared", o_overrun, 0);
        wait_tick(2000, delta);
        chk("t5_period_30", delta, 30);
        repeat (3) step();
        chk("t5_idx_before_hold", o_slot_idx, 2);
        i_enable = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("t5_no_tick", o_sample_tick, 0);
            if (o_frame_done === 1'b1) saw_done = 1'b1;
        end
        chk("t5_frame_completed", {31'd0, saw_done}, 1);
        chk("t5_idle_after", o_busy, 0);
        i_enable  = 1'b1;
        prev_tick = cyc;
        wait_tick(2000, delta);
        chk("t5_first_tick_after_enable", delta, 29);

        // 6: reset at idx 4
        repeat (5) step();
        chk("t6_idx_before_rst", o_slot_idx, 4);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("t6_valid_async", o_slot_valid, 0);
        chk("t6_busy_async",  o_busy,       0);
        chk("t6_idx_async",   o_slot_idx,   0);
        chk("t6_done_async",  o_frame_done, 0);
        @(posedge i_clk50mhz); #1;
        @(posedge i_clk50mhz); #1;
        i_rst_n   = 1'b1;
        prev_tick = cyc;
        wait_tick(2000, delta);
        chk("t6_first_tick_after_rst", delta, 1133);
        step();
        chk("t6_frame_valid", o_slot_valid, 1);
        chk("t6_frame_idx",   o_slot_idx,   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
